memory_arbiter: RTL and testbench

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter.sv | 118 +++++++++++
 tb/tb_memory_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// memory_arbiter: two-port (fetch/data) arbiter onto a single memory request bus
//   clk, rst                     clock, synchronous active-high reset
//   if_req_i/if_addr_i           fetch request; if_rdata_o/if_valid_o/if_abort_o response
//   d_req_i/d_addr_i/d_wdata_i/  data request (d_size_i: 1 = word, 0 = byte);
//   d_write_i/d_size_i           d_rdata_o/d_valid_o/d_abort_o response
//   addr_o/wdata_o/write_o/      memory request bus (trans_o = 2'b10 in the issue cycle)
//   size_o/prot_o/trans_o
//   rdata_i/data_valid_i/abort_i memory response; busy_o high while a transaction is open
module memory_arbiter #(
    parameter int unsigned TIMEOUT      = 15,
    parameter int unsigned MAX_DATA_RUN = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_valid_o,
    output logic        if_abort_o,
    input  logic        d_req_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    input  logic        d_write_i,
    input  logic        d_size_i,
    output logic [31:0] d_rdata_o,
    output logic        d_valid_o,
    output logic        d_abort_o,
    output logic [31:0] addr_o,
    output logic [31:0] wdata_o,
    output logic        write_o,
    output logic        size_o,
    output logic [1:0]  prot_o,
    output logic [1:0]  trans_o,
    input  logic [31:0] rdata_i,
    input  logic        data_valid_i,
    input  logic        abort_i,
    output logic        busy_o
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam int unsigned RW = $clog2(MAX_DATA_RUN + 1);
    state_t        state_q;
    logic [CW-1:0] wcnt_q;
    logic [RW-1:0] run_q;
    logic          owner_q;
    logic          pulse_d, pick_d, grant_d, expire_d;
    // A completion cycle arbitrates nothing: the finishing port still holds its
    // old request, and letting the other port in here would break run-based fairness.
    always_comb begin
        pulse_d  = if_valid_o | if_abort_o | d_valid_o | d_abort_o;
        pick_d   = d_req_i && !(if_req_i && run_q == RW'(MAX_DATA_RUN));
        grant_d  = !pulse_d && (if_req_i || d_req_i);
        expire_d = wcnt_q == CW'(TIMEOUT - 1);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wcnt_q     <= '0;
            run_q      <= '0;
            owner_q    <= 1'b0;
            addr_o     <= '0;
            wdata_o    <= '0;
            write_o    <= 1'b0;
            size_o     <= 1'b0;
            prot_o     <= 2'b00;
            trans_o    <= 2'b00;
            if_rdata_o <= '0;
            d_rdata_o  <= '0;
            if_valid_o <= 1'b0;
            if_abort_o <= 1'b0;
            d_valid_o  <= 1'b0;
            d_abort_o  <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            if_valid_o <= 1'b0;
            if_abort_o <= 1'b0;
            d_valid_o  <= 1'b0;
            d_abort_o  <= 1'b0;
            case (state_q)
                IDLE: if (grant_d) begin
                    state_q <= ISSUE;
                    owner_q <= pick_d;
                    addr_o  <= pick_d ? d_addr_i : if_addr_i;
                    wdata_o <= pick_d ? d_wdata_i : '0;
                    write_o <= pick_d & d_write_i;
                    size_o  <= pick_d ? d_size_i : 1'b1;
                    prot_o  <= pick_d ? 2'b01 : 2'b00;
                    trans_o <= 2'b10;
                    busy_o  <= 1'b1;
                    run_q   <= !pick_d ? '0 : (run_q == RW'(MAX_DATA_RUN) ? run_q : run_q + 1'b1);
                end
                ISSUE: begin
                    state_q <= WAIT;
                    trans_o <= 2'b00;
                    wcnt_q  <= '0;
                end
                WAIT: if (abort_i || data_valid_i || expire_d) begin
                    state_q <= IDLE;
                    busy_o  <= 1'b0;
                    wcnt_q  <= '0;
                    // abort wins over data_valid; a silent timeout is also an abort
                    if (abort_i || !data_valid_i) begin
                        if_abort_o <= !owner_q;
                        d_abort_o  <= owner_q;
                    end else begin
                        if_valid_o <= !owner_q;
                        d_valid_o  <= owner_q;
                        if (owner_q) d_rdata_o <= rdata_i;
                        else if_rdata_o <= rdata_i;
                    end
                end else begin
                    wcnt_q <= wcnt_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: randomized transaction-level check of memory_arbiter against a queue model
module tb_memory_arbiter;
    localparam int TO = 15;
    localparam int MR = 4;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req_i = 1'b0, d_req_i = 1'b0, d_write_i = 1'b0, d_size_i = 1'b0;
    logic [31:0] if_addr_i = '0, d_addr_i = '0, d_wdata_i = '0, rdata_i = '0;
    logic        data_valid_i = 1'b0, abort_i = 1'b0;
    logic [31:0] if_rdata_o, d_rdata_o, addr_o, wdata_o;
    logic        if_valid_o, if_abort_o, d_valid_o, d_abort_o, write_o, size_o, busy_o;
    logic [1:0]  prot_o, trans_o;
    always #5 clk = ~clk;
    memory_arbiter #(.TIMEOUT(TO), .MAX_DATA_RUN(MR)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o),
        .if_valid_o(if_valid_o), .if_abort_o(if_abort_o),
        .d_req_i(d_req_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_write_i(d_write_i), .d_size_i(d_size_i), .d_rdata_o(d_rdata_o),
        .d_valid_o(d_valid_o), .d_abort_o(d_abort_o),
        .addr_o(addr_o), .wdata_o(wdata_o), .write_o(write_o), .size_o(size_o),
        .prot_o(prot_o), .trans_o(trans_o), .rdata_i(rdata_i),
        .data_valid_i(data_valid_i), .abort_i(abort_i), .busy_o(busy_o)
    );
    typedef struct packed {logic [31:0] addr; logic [31:0] wdata; logic write; logic size;} txn_t;
    txn_t        fq[$], dq[$];
    int          tests = 0, fails = 0, cyc = 0;
    int          run = 0, wn = 0, lat = 0, mode = 0;
    int          force_mode = -1, force_lat = -1;
    int          issue_cyc = 0, done_cyc = 0, gn = 0;
    bit          busy_m = 0, own_d = 0, prev_if = 0, prev_d = 0, prev_pulse = 0, stray = 0, use_resp = 0;
    logic [31:0] resp = '0, force_resp = '0, exp_if_rdata = '0, exp_d_rdata = '0;
    logic [31:0] ghist = '0;
    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic txn_t mk(input logic [31:0] a, input logic [31:0] w, input logic wr, input logic sz);
        txn_t t;
        t.addr = a;
        t.wdata = w;
        t.write = wr;
        t.size = sz;
        return t;
    endfunction
    // One cycle: observe at the falling edge, compare against the model, then drive.
    task automatic tick();
        logic [3:0] pl;
        bit done, iexp;
        txn_t t;
        int r;
        @(negedge clk);
        cyc++;
        pl = {if_valid_o, if_abort_o, d_valid_o, d_abort_o};
        done = 0;
        data_valid_i = stray;
        abort_i = 1'b0;
        rdata_i = $urandom;
        stray = 0;
        if (rst) begin
            chk("rst_bus", {addr_o, wdata_o, write_o, size_o, prot_o, trans_o, busy_o, pl}, '0);
            chk("rst_rdata", {if_rdata_o, d_rdata_o}, '0);
            fq.delete();
            dq.delete();
            busy_m = 0;
            run = 0;
            exp_if_rdata = '0;
            exp_d_rdata = '0;
        end else begin
            if (busy_m && wn == (mode == 3 ? TO : lat + 1)) begin
                chk("done", {busy_o, trans_o, pl},
                    {1'b0, 2'b00, own_d ? {2'b00, mode == 0, mode != 0} : {mode == 0, mode != 0, 2'b00}});
                if (mode == 0) begin
                    if (own_d) exp_d_rdata = resp;
                    else exp_if_rdata = resp;
                end
                if (own_d) void'(dq.pop_front());
                else void'(fq.pop_front());
                busy_m = 0;
                done = 1;
                done_cyc = cyc;
            end else if (busy_m) begin
                chk("wait", {busy_o, trans_o, pl}, {1'b1, 2'b00, 4'b0000});
                if (mode != 3 && wn == lat) begin
                    data_valid_i = (mode != 1);
                    abort_i = (mode != 0);
                    rdata_i = resp;
                end
                wn++;
            end else begin
                iexp = (prev_if || prev_d) && !prev_pulse;
                chk("issue", {trans_o, busy_o, pl}, {iexp ? 2'b10 : 2'b00, iexp, 4'b0000});
                if (iexp && trans_o == 2'b10) begin
                    own_d = prev_d && !(prev_if && run == MR);
                    t = own_d ? dq[0] : fq[0];
                    chk("issue_bus", {addr_o, write_o, size_o, prot_o},
                        own_d ? {t.addr, t.write, t.size, 2'b01} : {t.addr, 1'b0, 1'b1, 2'b00});
                    if (own_d && t.write) chk("issue_wdata", wdata_o, t.wdata);
                    run = own_d ? (run < MR ? run + 1 : MR) : 0;
                    ghist = {ghist[30:0], own_d};
                    gn++;
                    issue_cyc = cyc;
                    r = $urandom_range(0, 19);
                    mode = force_mode >= 0 ? force_mode : (r < 13 ? 0 : r < 16 ? 1 : r < 19 ? 2 : 3);
                    lat = force_lat >= 0 ? force_lat : $urandom_range(0, 4);
                    resp = use_resp ? force_resp : $urandom;
                    busy_m = 1;
                    wn = 0;
                end
            end
            chk("rdata", {if_rdata_o, d_rdata_o}, {exp_if_rdata, exp_d_rdata});
        end
        prev_pulse = done;
        if_req_i = fq.size() > 0;
        if_addr_i = if_req_i ? fq[0].addr : $urandom;
        d_req_i = dq.size() > 0;
        d_addr_i = d_req_i ? dq[0].addr : $urandom;
        d_wdata_i = d_req_i ? dq[0].wdata : $urandom;
        d_write_i = d_req_i ? dq[0].write : 1'($urandom);
        d_size_i = d_req_i ? dq[0].size : 1'($urandom);
        prev_if = if_req_i;
        prev_d = d_req_i;
    endtask
    task automatic drain(input int budget);
        int n = 0;
        while ((fq.size() > 0 || dq.size() > 0 || busy_m) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_bound", n < budget, 1'b1);
    endtask
    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask
    initial begin
        int c0;
        do_reset();
        // single fetch with a fixed word and minimum latency
        force_mode = 0;
        force_lat = 0;
        use_resp = 1;
        force_resp = 32'hE3A01005;
        fq.push_back(mk(32'h100, 32'h0, 1'b0, 1'b1));
        tick();
        c0 = cyc;
        drain(40);
        chk("fetch_word", if_rdata_o, 32'hE3A01005);
        chk("fetch_latency", done_cyc - c0, 3);
        use_resp = 0;
        // simultaneous requests: data store first, then fetch
        force_lat = -1;
        gn = 0;
        fq.push_back(mk(32'h104, 32'h0, 1'b0, 1'b1));
        dq.push_back(mk(32'h200, 32'hDEADBEEF, 1'b1, 1'b1));
        drain(60);
        chk("simul_order", {gn, ghist[1:0]}, {32'd2, 2'b10});
        // starvation guard: four data grants, then a fetch, repeating
        do_reset();
        gn = 0;
        for (int i = 0; i < 10; i++) dq.push_back(mk($urandom, $urandom, 1'($urandom), 1'($urandom)));
        for (int i = 0; i < 2; i++) fq.push_back(mk($urandom, 32'h0, 1'b0, 1'b1));
        drain(300);
        chk("starve_order", {gn, ghist[11:0]}, {32'd12, 12'b1111_0111_1011});
        // silent memory: local timeout after 15 wait cycles
        force_mode = 3;
        dq.push_back(mk(32'h300, 32'h0, 1'b0, 1'b1));
        drain(60);
        chk("timeout_len", done_cyc - issue_cyc, 16);
        tick();
        chk("timeout_idle", {busy_o, trans_o}, 3'b000);
        // abort together with data_valid on a load
        force_mode = 2;
        dq.push_back(mk(32'h304, 32'h0, 1'b0, 1'b0));
        drain(40);
        // reset in the middle of WAIT, stray data_valid right after release
        force_mode = 3;
        fq.push_back(mk(32'h400, 32'h0, 1'b0, 1'b1));
        for (int i = 0; i < 20 && !(busy_m && wn >= 3); i++) tick();
        chk("mid_wait_reached", busy_m, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        stray = 1;
        repeat (3) tick();
        force_mode = 0;
        fq.push_back(mk(32'h408, 32'h0, 1'b0, 1'b1));
        drain(40);
        // randomized traffic
        force_mode = -1;
        for (int i = 0; i < 1500; i++) begin
            if (fq.size() < 3 && $urandom_range(0, 3) == 0) fq.push_back(mk($urandom, 32'h0, 1'b0, 1'b1));
            if (dq.size() < 3 && $urandom_range(0, 2) == 0) dq.push_back(mk($urandom, $urandom, 1'($urandom), 1'($urandom)));
            tick();
        end
        drain(400);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
